// File: rtl/ntt_stage_sched_pkg.sv
// Shared constants and FSM state encoding for the NTT stage scheduler.
package ntt_stage_sched_pkg;

    localparam int NTT_LOGN   = 8;
    localparam int NTT_BF_LAT = 4;
    localparam int NTT_RD_LAT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    // Depth of the in-flight tracking pipe: read latency plus butterfly latency.
    function automatic int track_depth(input int rd_lat, input int bf_lat);
        return rd_lat + bf_lat;
    endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational radix-2 DIT address generator: (stage, k) -> operand and twiddle addresses.
module ntt_addr_gen
    import ntt_stage_sched_pkg::*;
#(
    parameter int LOGN = NTT_LOGN
) (
    input  logic [LOGN-1:0] stage,
    input  logic [LOGN-2:0] k,
    output logic [LOGN-1:0] addr_a,
    output logic [LOGN-1:0] addr_b,
    output logic [LOGN-2:0] tw_addr
);

    localparam logic [LOGN-1:0] ONE        = LOGN'(1);
    localparam logic [LOGN-1:0] LAST_STAGE = LOGN'(LOGN - 1);

    logic [LOGN-2:0] off_mask;
    logic [LOGN-2:0] off;
    logic [LOGN-2:0] grp;
    logic [LOGN-1:0] half;
    logic [LOGN-1:0] base;
    logic [LOGN-1:0] tw_shift;

    always_comb begin
        half     = ONE << stage;
        off_mask = ~({(LOGN-1){1'b1}} << stage);
        off      = k & off_mask;
        grp      = k >> stage;
        // off < half, so bit 'stage' of base is always clear and OR equals add
        base     = ({1'b0, grp} << (stage + ONE)) | {1'b0, off};
        tw_shift = LAST_STAGE - stage;
        addr_a   = base;
        addr_b   = base | half;
        tw_addr  = off << tw_shift;
    end

endmodule

// File: rtl/ntt_stage_sched.sv
// In-place radix-2 DIT NTT stage scheduler: issues butterflies, tracks them, drains between stages.
// Optional build macro NTT_SCHED_HOLD_EN adds a 'hold' input that stalls issue.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_ISSUE | one butterfly read per cycle (unless held), k counts up
// ST_DRAIN | no reads; wait for in-flight butterflies of this stage
// ST_DONE  | one-cycle done pulse, then back to idle
module ntt_stage_sched
    import ntt_stage_sched_pkg::*;
#(
    parameter int LOGN   = NTT_LOGN,
    parameter int BF_LAT = NTT_BF_LAT,
    parameter int RD_LAT = NTT_RD_LAT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
`ifdef NTT_SCHED_HOLD_EN
    input  logic            hold,
`endif
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    output logic [LOGN-2:0] tw_addr,
    output logic            bf_en,
    input  logic            bf_valid,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b,
    output logic [LOGN-1:0] stage,
    output logic            err
);

    localparam int              PIPE_LEN   = track_depth(RD_LAT, BF_LAT);
    localparam logic [LOGN-1:0] LAST_STAGE = LOGN'(LOGN - 1);
    localparam logic [LOGN-2:0] K_LAST     = {(LOGN-1){1'b1}};

    sched_state_t state;
    sched_state_t state_nxt;

    logic [LOGN-2:0] k;
    logic            hold_i;
    logic            pipe_empty;
    logic [LOGN-1:0] ag_addr_a;
    logic [LOGN-1:0] ag_addr_b;
    logic [LOGN-2:0] ag_tw_addr;

    logic [PIPE_LEN-1:0]           pipe_v;
    logic [PIPE_LEN-1:0][LOGN-1:0] pipe_a;
    logic [PIPE_LEN-1:0][LOGN-1:0] pipe_b;

`ifdef NTT_SCHED_HOLD_EN
    assign hold_i = hold;
`else
    assign hold_i = 1'b0;
`endif

    ntt_addr_gen #(
        .LOGN (LOGN)
    ) u_addr_gen (
        .stage   (stage),
        .k       (k),
        .addr_a  (ag_addr_a),
        .addr_b  (ag_addr_b),
        .tw_addr (ag_tw_addr)
    );

    // The tail entry leaves this cycle, so the next stage may read the cycle after it.
    assign pipe_empty = ~|pipe_v[PIPE_LEN-2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (rd_en && (k == K_LAST)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_nxt = (stage == LAST_STAGE) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_en     = (state == ST_ISSUE) && !hold_i;
        busy      = (state == ST_ISSUE) || (state == ST_DRAIN);
        done      = (state == ST_DONE);
        rd_addr_a = rd_en ? ag_addr_a  : '0;
        rd_addr_b = rd_en ? ag_addr_b  : '0;
        tw_addr   = rd_en ? ag_tw_addr : '0;
        bf_en     = pipe_v[RD_LAT-1];
        wr_en     = pipe_v[PIPE_LEN-1];
        wr_addr_a = pipe_a[PIPE_LEN-1];
        wr_addr_b = pipe_b[PIPE_LEN-1];
    end

    // k saturates at K_LAST; only a stage change or a new transform returns it to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
            k     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        stage <= '0;
                        k     <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (rd_en && (k != K_LAST)) begin
                        k <= k + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (pipe_empty && (stage != LAST_STAGE)) begin
                        stage <= stage + 1'b1;
                        k     <= '0;
                    end
                end
                ST_DONE: begin
                    stage <= '0;
                    k     <= '0;
                end
                default: begin
                    stage <= '0;
                    k     <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
            pipe_a <= '0;
            pipe_b <= '0;
        end else begin
            pipe_v <= {pipe_v[PIPE_LEN-2:0], rd_en};
            pipe_a <= {pipe_a[PIPE_LEN-2:0], rd_addr_a};
            pipe_b <= {pipe_b[PIPE_LEN-2:0], rd_addr_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (bf_valid != pipe_v[PIPE_LEN-1]) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ntt_stage_sched.sv
// Scoreboard bench for ntt_stage_sched at LOGN=3; butterfly modelled as a BF_LAT delay line.
module tb_ntt_stage_sched;

    localparam int LOGN   = 3;
    localparam int BF_LAT = 4;
    localparam int RD_LAT = 1;

    // Hand-computed butterfly order for N=8: stage 0, stage 1, stage 2.
    localparam int EXP_A  [0:11] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    localparam int EXP_B  [0:11] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    localparam int EXP_TW [0:11] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] tw;
        logic [2:0] st;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic bf_force = 1'b0;
`ifdef NTT_SCHED_HOLD_EN
    logic hold = 1'b0;
`endif
    logic       busy, done, rd_en, bf_en, bf_valid, wr_en, err;
    logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, stage;
    logic [1:0] tw_addr;
    logic [BF_LAT-1:0] bf_dl;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int t0 = 0;
    int rel;
    int done_rel;
    int rd_n, wr_n;
    int first_rd [3];
    int last_wr  [3];
    int rd_cyc   [4];
    int wr_cyc   [4];
    int hz;
    logic prev_rd = 1'b0;
    txn_t rd_q [$];
    txn_t wr_q [$];
    txn_t pend [$];
    txn_t re, we;

    ntt_stage_sched #(
        .LOGN   (LOGN),
        .BF_LAT (BF_LAT),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
`ifdef NTT_SCHED_HOLD_EN
        .hold      (hold),
`endif
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .bf_en     (bf_en),
        .bf_valid  (bf_valid),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .stage     (stage),
        .err       (err)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bf_dl <= '0;
        else        bf_dl <= {bf_dl[BF_LAT-2:0], bf_en};
    end
    assign bf_valid = bf_dl[BF_LAT-1] | bf_force;

    function automatic void chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    task automatic new_run();
        txn_t e;
        t0 = cyc;
        done_rel = -1;
        rd_n = 0;
        wr_n = 0;
        for (int s = 0; s < 3; s++) begin
            first_rd[s] = -1;
            last_wr[s]  = -1;
        end
        for (int i = 0; i < 4; i++) begin
            rd_cyc[i] = -1;
            wr_cyc[i] = -1;
        end
        for (int i = 0; i < 12; i++) begin
            e.a  = 3'(EXP_A[i]);
            e.b  = 3'(EXP_B[i]);
            e.tw = 2'(EXP_TW[i]);
            e.st = 3'(i / 4);
            rd_q.push_back(e);
            wr_q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_within_budget", int'(n < limit), 1);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: pops expectations whenever the DUT reads or writes.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rd = 1'b0;
        end else begin
            rel = cyc - t0;
            if (bf_en || prev_rd) chk("bf_en_delay", int'(bf_en), int'(prev_rd));
            prev_rd = rd_en;
            if (done) done_rel = rel;
            if (rd_en) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    re = rd_q.pop_front();
                    chk("rd_txn", int'({rd_addr_a, rd_addr_b, tw_addr, stage}),
                        int'({re.a, re.b, re.tw, re.st}));
                    hz = 0;
                    foreach (pend[i]) begin
                        if (rd_addr_a == pend[i].a || rd_addr_a == pend[i].b ||
                            rd_addr_b == pend[i].a || rd_addr_b == pend[i].b) hz = 1;
                    end
                    chk("rd_hazard", hz, 0);
                    pend.push_back(re);
                    if (first_rd[re.st] < 0) first_rd[re.st] = rel;
                    if (rd_n < 4) rd_cyc[rd_n] = rel;
                    rd_n++;
                end
            end
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    we = wr_q.pop_front();
                    chk("wr_txn", int'({wr_addr_a, wr_addr_b}), int'({we.a, we.b}));
                    if (pend.size() > 0) void'(pend.pop_front());
                    last_wr[we.st] = rel;
                    if (wr_n < 4) wr_cyc[wr_n] = rel;
                    wr_n++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        chk("reset_outputs", int'({busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, bf_en,
                                   wr_en, wr_addr_a, wr_addr_b, stage, err}), 0);
        rst_n = 1'b1;
        step(2);

        // Run 1: plain transform, timing reference.
        new_run();
        pulse_start();
        chk("busy_after_start", int'(busy), 1);
        wait_done(80);
        chk("busy_in_done", int'(busy), 0);
        step(1);
        chk("r1_first_rd", rd_cyc[0], 1);
        chk("r1_fourth_rd", rd_cyc[3], 4);
        chk("r1_first_wr", wr_cyc[0], 6);
        chk("r1_fourth_wr", wr_cyc[3], 9);
        chk("r1_s0_last_wr", last_wr[0], 9);
        chk("r1_s1_first_rd", first_rd[1], 10);
        chk("r1_s2_first_rd", first_rd[2], 19);
        chk("r1_s2_last_wr", last_wr[2], 27);
        chk("r1_done", done_rel, 28);
        chk("r1_rd_left", rd_q.size(), 0);
        chk("r1_wr_left", wr_q.size(), 0);
        chk("r1_err", int'(err), 0);

        // Run 2: start while busy and in the done cycle, then one cycle after done.
        new_run();
        pulse_start();
        step(4);
        chk("r2_busy_mid", int'(busy), 1);
        pulse_start();
        wait_done(80);
        start = 1'b1;
        step(1);
        chk("r2_done", done_rel, 28);
        chk("r2_rd_left", rd_q.size(), 0);
        new_run();
        step(1);
        start = 1'b0;
        wait_done(80);
        step(1);
        chk("r3_first_rd", rd_cyc[0], 1);
        chk("r3_done", done_rel, 28);
        chk("r3_wr_left", wr_q.size(), 0);

        // Run 4: reset in the middle of stage 1.
        new_run();
        pulse_start();
        step(11);
        chk("r4_stage_before_rst", int'(stage), 1);
        rst_n = 1'b0;
        #1;
        chk("r4_reset_outputs", int'({busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, bf_en,
                                      wr_en, wr_addr_a, wr_addr_b, stage, err}), 0);
        rd_q.delete();
        wr_q.delete();
        pend.delete();
        step(2);
        rst_n = 1'b1;
        step(1);

        // Run 5: restart after reset begins at stage 0.
        new_run();
        pulse_start();
        wait_done(80);
        step(1);
        chk("r5_first_rd", rd_cyc[0], 1);
        chk("r5_s1_first_rd", first_rd[1], 10);
        chk("r5_done", done_rel, 28);
        chk("r5_err", int'(err), 0);

`ifdef NTT_SCHED_HOLD_EN
        // Hold for three cycles after the second stage-0 read.
        new_run();
        pulse_start();
        step(2);
        hold = 1'b1;
        step(3);
        hold = 1'b0;
        wait_done(80);
        step(1);
        chk("h_second_rd", rd_cyc[1], 2);
        chk("h_third_rd", rd_cyc[2], 6);
        chk("h_second_wr", wr_cyc[1], 7);
        chk("h_third_wr", wr_cyc[2], 11);
        chk("h_s1_first_rd", first_rd[1], 13);
        chk("h_done", done_rel, 31);
        chk("h_err", int'(err), 0);
`endif

        // Spurious bf_valid while idle sets the sticky error.
        chk("err_before_force", int'(err), 0);
        bf_force = 1'b1;
        step(1);
        bf_force = 1'b0;
        step(1);
        chk("err_set", int'(err), 1);
        step(5);
        chk("err_sticky", int'(err), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
